instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 101 ++++++++++
 tb/tb_instruction_fetch.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, stall, flush and redirect.
// Define FETCH_MISALIGN_TRAP_EN to turn misaligned redirect targets into a halting fault.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  input  logic        id_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc_plus4_o,
  output logic [31:0] if_instr_o,
  output logic        fault_o
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] IMEM_SIZE = 32'(IMEM_BYTES);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        if_valid_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_pc_plus4_q;
  logic [31:0] if_instr_q;
  logic        fault_q;

  logic        load_d;
  logic [31:0] pc_plus4_d;
  logic [31:0] seq_pc_d;
  logic [31:0] redir_pc_d;
  logic        misalign_d;

  // Handshake: the IF/ID word moves on when if_valid_o && id_ready_i at a rising
  // edge; an empty IF/ID register refills regardless of id_ready_i.
  assign load_d     = (state_q == RUN) && (!if_valid_q || id_ready_i);
  assign pc_plus4_d = pc_q + 32'd4;
  assign seq_pc_d   = (pc_plus4_d >= IMEM_SIZE) ? 32'd0 : pc_plus4_d;
  assign redir_pc_d = (redirect_pc_i & ~32'h3) % IMEM_SIZE;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_d = |redirect_pc_i[1:0];
`else
  assign misalign_d = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_pc_q       <= 32'd0;
      if_pc_plus4_q <= 32'd0;
      if_instr_q    <= NOP;
      fault_q       <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (redirect_i) begin
            // Flush wins over load; a faulting target leaves pc_q where it was.
            if_valid_q <= 1'b0;
            if_instr_q <= NOP;
            if (misalign_d) begin
              state_q <= HALT;
              fault_q <= 1'b1;
            end else begin
              pc_q <= redir_pc_d;
            end
          end else if (load_d) begin
            if_valid_q    <= 1'b1;
            if_pc_q       <= pc_q;
            if_pc_plus4_q <= pc_plus4_d;
            if_instr_q    <= imem_instr_i;
            pc_q          <= seq_pc_d;
          end
        end
        HALT: begin
          if_valid_q <= 1'b0;
          fault_q    <= 1'b1;
        end
      endcase
    end
  end

  assign imem_addr_o   = pc_q;
  assign if_valid_o    = if_valid_q;
  assign if_pc_o       = if_pc_q;
  assign if_pc_plus4_o = if_pc_plus4_q;
  assign if_instr_o    = if_instr_q;
  assign fault_o       = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized
// ready/redirect/reset traffic compared against a cycle-level reference model.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned IMEM_BYTES = 1024;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        fault;

  logic [7:0]  rom [0:IMEM_BYTES-1];

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  // Reference model state
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_if_pc;
  logic [31:0] m_if_p4;
  logic [31:0] m_instr;
  logic        m_fault;

  instruction_fetch #(
    .RESET_PC   (RESET_PC),
    .IMEM_BYTES (IMEM_BYTES)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_addr_o   (imem_addr),
    .imem_instr_i  (imem_instr),
    .id_ready_i    (id_ready),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .if_valid_o    (if_valid),
    .if_pc_o       (if_pc),
    .if_pc_plus4_o (if_pc_plus4),
    .if_instr_o    (if_instr),
    .fault_o       (fault)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian word read from the byte ROM
  assign imem_instr = {rom[{imem_addr[9:2], 2'd3}], rom[{imem_addr[9:2], 2'd2}],
                       rom[{imem_addr[9:2], 2'd1}], rom[{imem_addr[9:2], 2'd0}]};

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    int a;
    a = int'(addr % IMEM_BYTES) & ~3;
    return {rom[a+3], rom[a+2], rom[a+1], rom[a]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply the fetch rules to the model using the inputs about to be sampled.
  task automatic model_update();
    if (rst) begin
      m_pc = RESET_PC; m_valid = 1'b0; m_if_pc = 32'd0; m_if_p4 = 32'd0;
      m_instr = NOP; m_fault = 1'b0;
    end else if (m_fault) begin
      m_valid = 1'b0;
    end else if (redirect) begin
      m_valid = 1'b0;
      m_instr = NOP;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) m_fault = 1'b1;
      else m_pc = redirect_pc % IMEM_BYTES;
`else
      m_pc = {redirect_pc[31:2], 2'b00} % IMEM_BYTES;
`endif
    end else if (!m_valid || id_ready) begin
      m_instr = rom_word(m_pc);
      m_if_pc = m_pc;
      m_if_p4 = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = (m_pc + 32'd4) % IMEM_BYTES;
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check("imem_addr", imem_addr, m_pc);
    check("if_valid", 32'(if_valid), 32'(m_valid));
    check("fault", 32'(fault), 32'(m_fault));
    check("if_instr", if_instr, m_instr);
    if (m_valid) begin
      check("if_pc", if_pc, m_if_pc);
      check("if_pc_plus4", if_pc_plus4, m_if_p4);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] rp;
    logic [7:0]  prog [0:11];

    prog = '{8'h03, 8'h21, 8'h40, 8'h00, 8'h83, 8'h01, 8'h40, 8'h00, 8'h03, 8'h12, 8'h40, 8'h00};
    for (int i = 0; i < IMEM_BYTES; i++) rom[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 12; i++) rom[i] = prog[i];

    rst = 1'b1; id_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    m_pc = 32'd0; m_valid = 1'b0; m_if_pc = 32'd0; m_if_p4 = 32'd0; m_instr = NOP; m_fault = 1'b0;

    // Reset values
    do_reset();
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_instr", if_instr, NOP);
    check("rst_pc", if_pc, 32'd0);
    check("rst_pc_plus4", if_pc_plus4, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);

    // Straight-line fetch of the three-word program
    exp_q.push_back(32'h0040_2103);
    exp_q.push_back(32'h0040_0183);
    exp_q.push_back(32'h0040_1203);
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      w = exp_q.pop_front();
      check("prog_instr", if_instr, w);
      check("prog_pc", if_pc, 32'(4 * i));
      check("prog_pc_plus4", if_pc_plus4, 32'(4 * i + 4));
      check("prog_valid", 32'(if_valid), 32'd1);
    end

    // Stall while if_pc_o=4 keeps everything stable
    do_reset();
    id_ready = 1'b1;
    step();
    step();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", if_pc, 32'd4);
      check("stall_addr", imem_addr, 32'd8);
      check("stall_instr", if_instr, 32'h0040_0183);
    end
    id_ready = 1'b1;
    step();
    check("unstall_pc", if_pc, 32'd8);

    // Redirect flushes even without id_ready
    redirect = 1'b1; redirect_pc = 32'h30; id_ready = 1'b0;
    step();
    check("flush_valid", 32'(if_valid), 32'd0);
    check("flush_addr", imem_addr, 32'h30);
    check("flush_instr", if_instr, NOP);
    redirect = 1'b0;
    step();
    check("redir_pc", if_pc, 32'h30);
    check("redir_valid", 32'(if_valid), 32'd1);

    // Wrap at the top of the ROM
    redirect = 1'b1; redirect_pc = 32'h3FC;
    step();
    redirect = 1'b0; id_ready = 1'b1;
    step();
    check("wrap_pc_top", if_pc, 32'h3FC);
    check("wrap_pc_plus4", if_pc_plus4, 32'h400);
    step();
    check("wrap_pc_zero", if_pc, 32'h0);

    // Misaligned redirect target
    redirect = 1'b1; redirect_pc = 32'h32;
    step();
`ifdef FETCH_MISALIGN_TRAP_EN
    check("trap_fault", 32'(fault), 32'd1);
    check("trap_valid", 32'(if_valid), 32'd0);
    redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    step();
    check("halt_fault", 32'(fault), 32'd1);
    check("halt_valid", 32'(if_valid), 32'd0);
    do_reset();
    check("halt_cleared", 32'(fault), 32'd0);
`else
    redirect = 1'b0;
    step();
    check("misalign_pc", if_pc, 32'h30);
    check("misalign_fault", 32'(fault), 32'd0);
`endif

    // Reset during a stall with a valid word
    do_reset();
    id_ready = 1'b1;
    step();
    step();
    id_ready = 1'b0;
    step();
    check("pre_rst_valid", 32'(if_valid), 32'd1);
    rst = 1'b1;
    step();
    check("midstall_valid", 32'(if_valid), 32'd0);
    check("midstall_addr", imem_addr, RESET_PC);
    check("midstall_instr", if_instr, NOP);
    rst = 1'b0;

    // Randomized ready / redirect / reset traffic
    for (int n = 0; n < 600; n++) begin
      id_ready = ($urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 39) == 0);
      redirect = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       rp = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        1:       rp = $urandom;
        2:       rp = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        default: rp = 32'h3FC;
      endcase
      redirect_pc = rp;
      step();
    end
    rst = 1'b0; redirect = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
